// File: rtl/edulent_dp_pkg.sv
// Shared encodings for the Edulent accumulator datapath:
// transfer commands, ALU operations, jump conditions, memory FSM.
package edulent_dp_pkg;

    typedef enum logic [3:0] {
        CMD_NOP      = 4'd0,
        CMD_MA_PC    = 4'd1,
        CMD_IR_MD    = 4'd2,
        CMD_MA_MD    = 4'd3,
        CMD_LOAD_DST = 4'd4,
        CMD_MA_AP    = 4'd5,
        CMD_MA_SP    = 4'd6,
        CMD_MD_SRC   = 4'd7,
        CMD_A_IN     = 4'd8,
        CMD_OUT_A    = 4'd9,
        CMD_PC_AP    = 4'd10,
        CMD_MD_PC    = 4'd11,
        CMD_JMP      = 4'd12,
        CMD_MEM_RD   = 4'd13,
        CMD_MEM_WR   = 4'd14,
        CMD_ALU      = 4'd15
    } cmd_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_NOT  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_AND  = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SHR  = 4'd6,
        ALU_SHL  = 4'd7,
        ALU_PASS = 4'd8
    } alu_op_e;

    localparam logic [1:0] COND_ALWAYS = 2'd0;
    localparam logic [1:0] COND_Z      = 2'd1;
    localparam logic [1:0] COND_C      = 2'd2;
    localparam logic [1:0] COND_NEVER  = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/edulent_datapath_p_alu.sv
// Combinational ALU: result and C/Z flags derived from one
// DATA_W+1 wide intermediate so flags never lag the result.
module edulent_alu
    import edulent_dp_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] res,
    output logic              c,
    output logic              z
);

    logic [DATA_W:0] ext;

    always_comb begin
        ext = '0;
        c   = 1'b0;
        case (op)
            ALU_ADD: begin
                ext = {1'b0, a} + {1'b0, b};
                c   = ext[DATA_W];
            end
            ALU_SUB: begin
                ext = {1'b0, a} - {1'b0, b};
                c   = ext[DATA_W];
            end
            ALU_NOT: ext = {1'b0, ~a};
            ALU_OR:  ext = {1'b0, a | b};
            ALU_AND: ext = {1'b0, a & b};
            ALU_XOR: ext = {1'b0, a ^ b};
            ALU_SHR: begin
                ext = {2'b00, a[DATA_W-1:1]};
                c   = a[0];
            end
            ALU_SHL: begin
                ext = {1'b0, a[DATA_W-2:0], 1'b0};
                c   = a[DATA_W-1];
            end
            default: ext = {1'b0, a};
        endcase
    end

    assign res = ext[DATA_W-1:0];
    assign z   = (res == '0);

endmodule

// File: rtl/edulent_datapath_p.sv
// Edulent datapath: architectural registers, one transfer per
// handshake, and a two-state valid/ack memory port FSM.
module edulent_datapath_p
    import edulent_dp_pkg::*;
#(
    parameter int              DATA_W  = 8,
    parameter int              ADDR_W  = 8,
    parameter logic [ADDR_W-1:0] SP_INIT = '1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [3:0]        i_cmd,
    input  logic [3:0]        i_alu_op,
    input  logic              i_dst_ap,
    input  logic [1:0]        i_cond,
    input  logic              i_pc_inc,
    input  logic [1:0]        i_sp_op,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_in,
    output logic [DATA_W-1:0] o_out,
    output logic [DATA_W-1:0] o_ir,
    output logic [1:0]        o_flags
);

    logic [ADDR_W-1:0] pc, sp, ma;
    logic [DATA_W-1:0] ir, md, a, ap, r, outr;
    logic              c, z, mem_req, mem_we;
    state_e            state;

    logic [DATA_W-1:0] alu_res, src;
    logic              alu_c, alu_z, alu_ok;
    logic              hs, jmp_ok, pc_wr;
    cmd_e              cmd;
    logic              unused_r;

    function automatic logic [ADDR_W-1:0] d2a(input logic [DATA_W-1:0] d);
        return ADDR_W'(d);
    endfunction

    function automatic logic [DATA_W-1:0] a2d(input logic [ADDR_W-1:0] v);
        return DATA_W'(v);
    endfunction

    edulent_alu #(.DATA_W(DATA_W)) u_alu (
        .a   (a),
        .b   (md),
        .op  (alu_op_e'(i_alu_op)),
        .res (alu_res),
        .c   (alu_c),
        .z   (alu_z)
    );

    assign cmd    = cmd_e'(i_cmd);
    assign hs     = i_cmd_valid && o_cmd_ready;
    assign alu_ok = (i_alu_op <= ALU_PASS);
    assign src    = i_dst_ap ? ap : a;

    always_comb begin
        jmp_ok = 1'b0;
        case (i_cond)
            COND_ALWAYS: jmp_ok = 1'b1;
            COND_Z:      jmp_ok = z;
            COND_C:      jmp_ok = c;
            default:     jmp_ok = 1'b0;
        endcase
    end

    // A taken jump or PC_AP overrides the sequential increment
    assign pc_wr = (cmd == CMD_PC_AP) || (cmd == CMD_JMP && jmp_ok);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pc      <= '0;
            sp      <= SP_INIT;
            ma      <= '0;
            ir      <= '0;
            md      <= '0;
            a       <= '0;
            ap      <= '0;
            r       <= '0;
            outr    <= '0;
            c       <= 1'b0;
            z       <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= ST_IDLE;
        end else if (hs) begin
            if (i_pc_inc && !pc_wr) pc <= pc + 1'b1;
            case (i_sp_op)
                2'b01:   sp <= sp + 1'b1;
                2'b10:   sp <= sp - 1'b1;
                default: ;
            endcase
            case (cmd)
                CMD_MA_PC:    ma <= pc;
                CMD_IR_MD:    ir <= md;
                CMD_MA_MD:    ma <= d2a(md);
                CMD_LOAD_DST: if (i_dst_ap) ap <= md; else a <= md;
                CMD_MA_AP:    ma <= d2a(ap);
                CMD_MA_SP:    ma <= sp;
                CMD_MD_SRC:   md <= src;
                CMD_A_IN:     a <= i_in;
                CMD_OUT_A:    outr <= a;
                CMD_PC_AP:    pc <= d2a(ap);
                CMD_MD_PC:    md <= a2d(pc);
                CMD_JMP:      if (jmp_ok) pc <= d2a(md);
                CMD_MEM_RD, CMD_MEM_WR: begin
                    state   <= ST_WAIT;
                    mem_req <= 1'b1;
                    mem_we  <= (cmd == CMD_MEM_WR);
                end
                CMD_ALU: if (alu_ok) begin
                    r <= alu_res;
                    if (i_dst_ap) ap <= alu_res; else a <= alu_res;
                    c <= alu_c;
                    z <= alu_z;
                end
                default: ;
            endcase
        end else if (state == ST_WAIT && i_mem_ack) begin
            if (!mem_we) md <= i_mem_rdata;
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
        end
    end

    assign unused_r    = ^r;
    assign o_cmd_ready = (state == ST_IDLE);
    assign o_mem_req   = mem_req;
    assign o_mem_we    = mem_we;
    assign o_mem_addr  = ma;
    assign o_mem_wdata = md;
    assign o_out       = outr;
    assign o_ir        = ir;
    assign o_flags     = {c, z};

endmodule

// File: tb/tb_edulent_datapath_p.sv
// Directed bench for edulent_datapath_p: 8-bit and 16-bit
// data instances driven from one initial block.
module tb_edulent_datapath_p;
    import edulent_dp_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    logic       rstn8, valid8, ready8, ap8, inc8, req8, we8, ack8;
    logic [3:0] cmd8, op8;
    logic [1:0] cond8, sp8, flags8;
    logic [7:0] addr8, wdata8, rdata8, in8, out8, ir8;

    logic        rstn16, valid16, ready16, ap16, inc16, req16, we16, ack16;
    logic [3:0]  cmd16, op16;
    logic [1:0]  cond16, sp16, flags16;
    logic [7:0]  addr16;
    logic [15:0] wdata16, rdata16, in16, out16, ir16;

    edulent_datapath_p dut8 (
        .i_clk(clk), .i_rstn(rstn8),
        .i_cmd_valid(valid8), .o_cmd_ready(ready8),
        .i_cmd(cmd8), .i_alu_op(op8), .i_dst_ap(ap8),
        .i_cond(cond8), .i_pc_inc(inc8), .i_sp_op(sp8),
        .o_mem_req(req8), .o_mem_we(we8),
        .o_mem_addr(addr8), .o_mem_wdata(wdata8),
        .i_mem_rdata(rdata8), .i_mem_ack(ack8),
        .i_in(in8), .o_out(out8), .o_ir(ir8), .o_flags(flags8)
    );

    edulent_datapath_p #(.DATA_W(16), .ADDR_W(8)) dut16 (
        .i_clk(clk), .i_rstn(rstn16),
        .i_cmd_valid(valid16), .o_cmd_ready(ready16),
        .i_cmd(cmd16), .i_alu_op(op16), .i_dst_ap(ap16),
        .i_cond(cond16), .i_pc_inc(inc16), .i_sp_op(sp16),
        .o_mem_req(req16), .o_mem_we(we16),
        .o_mem_addr(addr16), .o_mem_wdata(wdata16),
        .i_mem_rdata(rdata16), .i_mem_ack(ack16),
        .i_in(in16), .o_out(out16), .o_ir(ir16), .o_flags(flags16)
    );

    // Called at a negedge; one handshake, returns at the next negedge
    task automatic issue8(input logic [3:0] c, input logic [7:0] d);
        cmd8 = c; in8 = d; valid8 = 1'b1;
        @(negedge clk);
        valid8 = 1'b0; op8 = '0; ap8 = 1'b0;
        cond8 = '0; inc8 = 1'b0; sp8 = '0;
    endtask

    task automatic issue16(input logic [3:0] c, input logic [15:0] d);
        cmd16 = c; in16 = d; valid16 = 1'b1;
        @(negedge clk);
        valid16 = 1'b0; ap16 = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        if ({ready8, req8, we8} !== 3'b100) begin
            $display("FAIL reset_hs: got %b want 100", {ready8, req8, we8});
            nmis++;
        end
        nvec++;
        if ({addr8, wdata8, out8, ir8, flags8} !== 34'd0) begin
            $display("FAIL reset_regs: got %h want 0",
                     {addr8, wdata8, out8, ir8, flags8});
            nmis++;
        end
        nvec++;
        @(negedge clk);
        rstn8 = 1'b1; rstn16 = 1'b1;
        @(negedge clk);
        issue8(CMD_MA_SP, 8'h00);
        if (addr8 !== 8'hFF) begin
            $display("FAIL reset_sp: got %h want ff", addr8);
            nmis++;
        end
        nvec++;
    endtask

    task automatic test_alu;
        issue8(CMD_A_IN, 8'h01);
        issue8(CMD_MD_SRC, 8'h00);
        issue8(CMD_A_IN, 8'hFF);
        op8 = ALU_ADD; issue8(CMD_ALU, 8'h00);
        if (flags8 !== 2'b11) begin
            $display("FAIL add_flags: got %b want 11", flags8);
            nmis++;
        end
        nvec++;
        issue8(CMD_OUT_A, 8'h00);
        if (out8 !== 8'h00) begin
            $display("FAIL add_res: got %h want 00", out8);
            nmis++;
        end
        nvec++;
        op8 = ALU_SUB; issue8(CMD_ALU, 8'h00);
        issue8(CMD_OUT_A, 8'h00);
        if ({out8, flags8} !== {8'hFF, 2'b10}) begin
            $display("FAIL sub: got %h/%b want ff/10", out8, flags8);
            nmis++;
        end
        nvec++;
        issue8(CMD_A_IN, 8'h3C);
        issue8(CMD_MD_SRC, 8'h00);
        op8 = ALU_XOR; ap8 = 1'b1; issue8(CMD_ALU, 8'h00);
        issue8(CMD_MA_AP, 8'h00);
        issue8(CMD_OUT_A, 8'h00);
        if ({addr8, out8, flags8} !== {8'h00, 8'h3C, 2'b01}) begin
            $display("FAIL xor_ap: got %h/%h/%b want 00/3c/01",
                     addr8, out8, flags8);
            nmis++;
        end
        nvec++;
        op8 = 4'hF; issue8(CMD_ALU, 8'h00);
        issue8(CMD_OUT_A, 8'h00);
        if ({out8, flags8} !== {8'h3C, 2'b01}) begin
            $display("FAIL undef_op: got %h/%b want 3c/01", out8, flags8);
            nmis++;
        end
        nvec++;
        issue8(CMD_A_IN, 8'h81);
        op8 = ALU_SHL; issue8(CMD_ALU, 8'h00);
        issue8(CMD_OUT_A, 8'h00);
        if ({out8, flags8} !== {8'h02, 2'b10}) begin
            $display("FAIL shl: got %h/%b want 02/10", out8, flags8);
            nmis++;
        end
        nvec++;
        op8 = ALU_SHR; issue8(CMD_ALU, 8'h00);
        issue8(CMD_OUT_A, 8'h00);
        if ({out8, flags8} !== {8'h01, 2'b00}) begin
            $display("FAIL shr: got %h/%b want 01/00", out8, flags8);
            nmis++;
        end
        nvec++;
    endtask

    task automatic test_mem;
        int n;
        issue8(CMD_A_IN, 8'h10);
        issue8(CMD_MD_SRC, 8'h00);
        issue8(CMD_MA_MD, 8'h00);
        issue8(CMD_MEM_RD, 8'h00);
        if ({req8, we8, ready8, addr8} !== {3'b100, 8'h10}) begin
            $display("FAIL rd_start: got %b/%h want 100/10",
                     {req8, we8, ready8}, addr8);
            nmis++;
        end
        nvec++;
        cmd8 = CMD_A_IN; in8 = 8'h77; valid8 = 1'b1;
        n = 0;
        for (int i = 0; i < 10 && !ready8; i++) begin
            n++;
            if (n == 3) begin ack8 = 1'b1; rdata8 = 8'h5A; end
            @(negedge clk);
            ack8 = 1'b0;
        end
        valid8 = 1'b0;
        if (n !== 3 || req8 !== 1'b0) begin
            $display("FAIL rd_wait: got %0d/%b want 3/0", n, req8);
            nmis++;
        end
        nvec++;
        if (wdata8 !== 8'h5A) begin
            $display("FAIL rd_data: got %h want 5a", wdata8);
            nmis++;
        end
        nvec++;
        issue8(CMD_OUT_A, 8'h00);
        if (out8 !== 8'h10) begin
            $display("FAIL rd_ignore: got %h want 10", out8);
            nmis++;
        end
        nvec++;
        issue8(CMD_A_IN, 8'h99);
        issue8(CMD_MD_SRC, 8'h00);
        issue8(CMD_MEM_WR, 8'h00);
        if ({req8, we8, ready8, wdata8} !== {3'b110, 8'h99}) begin
            $display("FAIL wr_start: got %b/%h want 110/99",
                     {req8, we8, ready8}, wdata8);
            nmis++;
        end
        nvec++;
        ack8 = 1'b1; rdata8 = 8'hAA;
        @(negedge clk);
        ack8 = 1'b0;
        if ({req8, we8, ready8, wdata8} !== {3'b001, 8'h99}) begin
            $display("FAIL wr_done: got %b/%h want 001/99",
                     {req8, we8, ready8}, wdata8);
            nmis++;
        end
        nvec++;
    endtask

    task automatic test_sp_pc;
        sp8 = 2'b01; issue8(CMD_NOP, 8'h00);
        issue8(CMD_MA_SP, 8'h00);
        if (addr8 !== 8'h00) begin
            $display("FAIL sp_inc_wrap: got %h want 00", addr8);
            nmis++;
        end
        nvec++;
        sp8 = 2'b10; issue8(CMD_NOP, 8'h00);
        issue8(CMD_MA_SP, 8'h00);
        if (addr8 !== 8'hFF) begin
            $display("FAIL sp_dec_wrap: got %h want ff", addr8);
            nmis++;
        end
        nvec++;
        issue8(CMD_A_IN, 8'hFF);
        issue8(CMD_MD_SRC, 8'h00);
        ap8 = 1'b1; issue8(CMD_LOAD_DST, 8'h00);
        issue8(CMD_PC_AP, 8'h00);
        inc8 = 1'b1; issue8(CMD_NOP, 8'h00);
        issue8(CMD_MA_PC, 8'h00);
        if (addr8 !== 8'h00) begin
            $display("FAIL pc_wrap: got %h want 00", addr8);
            nmis++;
        end
        nvec++;
        issue8(CMD_A_IN, 8'h40);
        issue8(CMD_MD_SRC, 8'h00);
        inc8 = 1'b1; cond8 = COND_ALWAYS; issue8(CMD_JMP, 8'h00);
        issue8(CMD_MA_PC, 8'h00);
        if (addr8 !== 8'h40) begin
            $display("FAIL jmp_over_inc: got %h want 40", addr8);
            nmis++;
        end
        nvec++;
    endtask

    task automatic test_jmp_cond;
        issue8(CMD_A_IN, 8'h22);
        issue8(CMD_MD_SRC, 8'h00);
        op8 = ALU_PASS; issue8(CMD_ALU, 8'h00);
        cond8 = COND_Z; issue8(CMD_JMP, 8'h00);
        issue8(CMD_MA_PC, 8'h00);
        if (addr8 !== 8'h40) begin
            $display("FAIL jmp_z_not: got %h want 40", addr8);
            nmis++;
        end
        nvec++;
        op8 = ALU_SUB; issue8(CMD_ALU, 8'h00);
        cond8 = COND_Z; issue8(CMD_JMP, 8'h00);
        issue8(CMD_MA_PC, 8'h00);
        if (addr8 !== 8'h22) begin
            $display("FAIL jmp_z_taken: got %h want 22", addr8);
            nmis++;
        end
        nvec++;
        issue8(CMD_IR_MD, 8'h00);
        if (ir8 !== 8'h22) begin
            $display("FAIL ir_md: got %h want 22", ir8);
            nmis++;
        end
        nvec++;
    endtask

    task automatic test_back_to_back;
        logic rdy_ok;
        rdy_ok = 1'b1;
        issue8(CMD_A_IN, 8'h11);
        rdy_ok &= ready8;
        issue8(CMD_MD_SRC, 8'h00);
        rdy_ok &= ready8;
        issue8(CMD_MA_MD, 8'h00);
        rdy_ok &= ready8;
        issue8(CMD_OUT_A, 8'h00);
        if ({rdy_ok, addr8, out8} !== {1'b1, 8'h11, 8'h11}) begin
            $display("FAIL b2b: got %b/%h/%h want 1/11/11",
                     rdy_ok, addr8, out8);
            nmis++;
        end
        nvec++;
    endtask

    task automatic test_wide;
        issue16(CMD_A_IN, 16'hABCD);
        issue16(CMD_MD_SRC, 16'h0);
        issue16(CMD_MA_MD, 16'h0);
        if (addr16 !== 8'hCD) begin
            $display("FAIL w_ma_md: got %h want cd", addr16);
            nmis++;
        end
        nvec++;
        issue16(CMD_A_IN, 16'h0012);
        issue16(CMD_MD_SRC, 16'h0);
        ap16 = 1'b1; issue16(CMD_LOAD_DST, 16'h0);
        issue16(CMD_PC_AP, 16'h0);
        issue16(CMD_A_IN, 16'hFFFF);
        issue16(CMD_MD_SRC, 16'h0);
        issue16(CMD_MD_PC, 16'h0);
        if (wdata16 !== 16'h0012) begin
            $display("FAIL w_md_pc: got %h want 0012", wdata16);
            nmis++;
        end
        nvec++;
        issue16(CMD_MEM_RD, 16'h0);
        if (req16 !== 1'b1) begin
            $display("FAIL w_rd_req: got %b want 1", req16);
            nmis++;
        end
        nvec++;
        #2 rstn16 = 1'b0;
        #1;
        if ({req16, ready16} !== 2'b01) begin
            $display("FAIL w_rst_wait: got %b want 01", {req16, ready16});
            nmis++;
        end
        nvec++;
        @(negedge clk);
        rstn16 = 1'b1;
    endtask

    initial begin
        rstn8 = 1'b0; valid8 = 1'b0; cmd8 = '0; op8 = '0; ap8 = 1'b0;
        cond8 = '0; inc8 = 1'b0; sp8 = '0; ack8 = 1'b0;
        rdata8 = '0; in8 = '0;
        rstn16 = 1'b0; valid16 = 1'b0; cmd16 = '0; op16 = '0;
        ap16 = 1'b0; cond16 = '0; inc16 = 1'b0; sp16 = '0;
        ack16 = 1'b0; rdata16 = '0; in16 = '0;
        test_reset;
        test_alu;
        test_mem;
        test_sp_pc;
        test_jmp_cond;
        test_back_to_back;
        test_wide;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/edulent_datapath_p.md
# edulent_datapath_p

Parametrised datapath for the Edulent accumulator CPU. It executes one register-transfer command per handshake from the control unit and moves data between the architectural registers PC, IR, SP, MA, MD, A, AP, R, IN and OUT. It drives a valid/ack memory port that tolerates wait states. The ALU produces its result and the C/Z flags in the same cycle and writes back to A or AP. The block sits between the control FSM and the memory/IO fabric.

## Interface
- DATA_W, 8: width of A, AP, R, MD, IR, IN, OUT; must be ≥ 4.
- ADDR_W, 8: width of PC, SP, MA and the memory address.
- SP_INIT, 2**ADDR_W-1: SP value after reset.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  datapath can accept a command.
- i_cmd  in  4  transfer command (cmd_e).
- i_alu_op  in  4  ALU operation (alu_op_e); sampled with CMD_ALU.
- i_dst_ap  in  1  selects AP instead of A as destination for LOAD_DST and CMD_ALU, and as source for MD_SRC.
- i_cond  in  2  jump condition: 0 always, 1 Z, 2 C, 3 never.
- i_pc_inc  in  1  increment PC on handshake.
- i_sp_op  in  2  01 increment, 10 decrement, others hold; applied on handshake.
- o_mem_req  out  1  memory request.
- o_mem_we  out  1  write when 1.
- o_mem_addr  out  ADDR_W  equals MA.
- o_mem_wdata  out  DATA_W  equals MD.
- i_mem_rdata  in  DATA_W  read data; valid with ack.
- i_mem_ack  in  1  completes the outstanding request.
- i_in  in  DATA_W  input port.
- o_out  out  DATA_W  OUT register.
- o_ir  out  DATA_W  IR, for decode.
- o_flags  out  2  {C, Z}.

## Operation
- A handshake occurs when i_cmd_valid and o_cmd_ready are both high. All side inputs are sampled only on a handshake.
- Register commands:
  - NOP: no transfer.
  - MA_PC: MA←PC.
  - IR_MD: IR←MD.
  - MA_MD: MA←MD.
  - LOAD_DST: A or AP ←MD.
  - MA_AP: MA←AP.
  - MA_SP: MA←SP.
  - MD_SRC: MD←A or AP.
  - A_IN: A←i_in.
  - OUT_A: OUT←A.
  - PC_AP: PC←AP.
  - MD_PC: MD←PC.
  - JMP: PC←MD if i_cond holds.
- Width rule: address←data transfers take the low ADDR_W bits, zero-extended if DATA_W < ADDR_W. Data←address transfers zero-extend or truncate the same way.
- MEM_RD and MEM_WR move the FSM from IDLE to WAIT. In WAIT, o_mem_req=1 and o_mem_we=1 for writes. On the cycle i_mem_ack=1: MD←i_mem_rdata for a read, then return to IDLE.
- ALU command: R and the destination (A or AP) get res in a single edge. C and Z are computed from the same res, never from a stale value.
- ALU results (all in DATA_W+1 arithmetic):
  - ADD: A+MD, C=carry out.
  - SUB: A−MD, C=borrow.
  - NOT: ~A.
  - OR, AND, XOR: A op MD.
  - SHR: A>>1, C=A[0].
  - SHL: A<<1, C=A[MSB].
  - PASS: A.
  - Logic ops and PASS set C=0. Z=(res==0) for every op.
- Flags change only on CMD_ALU.
- PC increment and SP operations wrap modulo 2^ADDR_W.
- If the command writes PC in the same handshake as i_pc_inc=1, the command write wins and no increment occurs.
- An undefined i_cmd or i_alu_op behaves as NOP; flags hold.

## Timing
- Reset values:
  - All registers 0, except SP=SP_INIT.
  - FSM in IDLE, so o_cmd_ready=1, o_mem_req=0, o_mem_we=0.
  - o_out=0, o_ir=0, o_flags=0.
- Register and ALU commands: result visible on the edge ending the handshake cycle. o_cmd_ready stays 1, giving back-to-back throughput of 1 command per cycle.
- Memory commands:
  - Handshake at cycle N.
  - o_mem_req=1 and o_cmd_ready=0 from N+1 until the ack cycle, inclusive.
  - o_cmd_ready=1 the cycle after ack.
  - Minimum latency is 2 cycles, when ack arrives at N+1.
- o_mem_addr and o_mem_wdata stay stable while o_mem_req=1.
- i_mem_ack is ignored while o_mem_req=0.
- Reset asserted mid-WAIT forces o_mem_req=0 asynchronously and abandons the access.

## Structure
- The package edulent_dp_pkg holds:
  - cmd_e and alu_op_e enums.
  - Condition encodings.
  - FSM state typedef {IDLE, WAIT}.
- Sub-module edulent_alu: combinational, parametrised by DATA_W. Ports: a, b, op, res, c, z.
- All registers live in a single always_ff block in the top module.

## Test plan
- Reset with DATA_W=8 -> SP=0xFF, o_cmd_ready=1, o_mem_req=0, all other outputs 0.
- A=0xFF, MD=0x01, ALU ADD -> A=0x00, C=1, Z=1 on the same edge. Then SUB with A=0x00, MD=0x01 -> A=0xFF, C=1, Z=0.
- MEM_RD with MA=0x10, ack delayed 3 cycles, rdata 0x5A -> o_cmd_ready low for 3 cycles, MD=0x5A, valid ignored meanwhile.
- SP=0x00 with i_sp_op=10 -> SP=0xFF. PC=0xFF with i_pc_inc -> PC=0x00. JMP with i_pc_inc=1 and MD=0x40 -> PC=0x40.
- JMP i_cond=1 with Z=0 -> PC unchanged. Then with Z=1 and MD=0x22 -> PC=0x22.
- DATA_W=16, ADDR_W=8: MA_MD with MD=0xABCD -> MA=0xCD. MD_PC with PC=0x12 -> MD=0x0012. Reset during WAIT -> o_mem_req drops immediately.
